// File: rtl/ahb_params_pkg.sv
// ahb_params_pkg: AHB-Lite encodings, data-phase tracker states and lane helpers
package ahb_params_pkg;
    typedef enum logic [1:0] {HTRANS_IDLE = 2'b00, HTRANS_BUSY = 2'b01, HTRANS_NONSEQ = 2'b10, HTRANS_SEQ = 2'b11} htrans_t;
    typedef enum logic [1:0] {HRESP_OKAY = 2'b00, HRESP_ERROR = 2'b01} hresp_t;
    typedef enum logic [2:0] {HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2} hsize_t;
    typedef enum logic [2:0] {HBURST_SINGLE = 3'd0} hburst_t;
    typedef enum logic [1:0] {D_IDLE, D_ACT, D_ERR} dstate_t;
    localparam logic [3:0] HPROT_DATA_PRIV = 4'b0011;

    // size code 3 is illegal and promoted to a word transfer
    function automatic hsize_t to_hsize(input logic [1:0] s);
        return s == 2'd0 ? HSIZE_BYTE : s == 2'd1 ? HSIZE_HALF : HSIZE_WORD;
    endfunction

    function automatic logic [31:0] lane_replicate(input logic [31:0] d, input hsize_t s);
        return s == HSIZE_BYTE ? {4{d[7:0]}} : s == HSIZE_HALF ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] d, input logic [1:0] lo, input hsize_t s);
        logic [31:0] w;
        w = d >> {lo, 3'b000};
        return s == HSIZE_BYTE ? {24'b0, w[7:0]} : s == HSIZE_HALF ? {16'b0, w[15:0]} : w;
    endfunction
endpackage

// File: rtl/ahb_lite_master_if.sv
// ahb_lite_master_if: command/response channel plus AHB-Lite master bus signals
interface ahb_lite_master_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [1:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;
    logic [ADDR_W-1:0] HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [2:0]        HBURST;
    logic [3:0]        HPROT;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic [1:0]        HRESP;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HREADY, HRESP,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );
    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata, HRDATA, HREADY, HRESP,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: pipelined single-transfer AHB-Lite master with in-order responses
// and cancellation of the queued address phase on a two-cycle ERROR.
module ahb_lite_master
    import ahb_params_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input logic HCLK,
    input logic HRESET,
    ahb_lite_master_if.master bus
);
    dstate_t           r_dstate, w_dstate_nx;
    htrans_t           r_htrans;
    logic [ADDR_W-1:0] r_haddr;
    logic              r_hwrite;
    hsize_t            r_hsize;
    logic [DATA_W-1:0] r_awdata, r_hwdata;
    logic              r_d_write;
    hsize_t            r_d_size;
    logic [1:0]        r_d_lo;
    logic              r_up, r_cancel, r_cxl_rsp;
    logic              r_rsp_valid, r_rsp_error;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              w_err, w_pend, w_addr_done, w_data_done, w_cancel, w_ready, w_accept, w_rsp_err, w_err_end;

    assign w_err       = bus.HRESP == HRESP_ERROR;
    assign w_pend      = r_htrans == HTRANS_NONSEQ;
    assign w_addr_done = w_pend && bus.HREADY;
    assign w_data_done = r_dstate != D_IDLE && bus.HREADY;
    assign w_err_end   = r_dstate == D_ERR && bus.HREADY;
    assign w_cancel    = r_dstate == D_ACT && !bus.HREADY && w_err && w_pend;
    // r_cancel blocks new commands until the cancelled response has been ordered behind the error
    assign w_ready     = r_up && !r_cancel && (!w_pend || (bus.HREADY && bus.HRESP == HRESP_OKAY));
    assign w_accept    = w_ready && bus.cmd_valid;
    assign w_rsp_err   = r_dstate == D_ERR || w_err;

    always_comb begin
        w_dstate_nx = r_dstate;
        if (r_dstate == D_ACT && !bus.HREADY && w_err) w_dstate_nx = D_ERR;
        else if (r_dstate == D_IDLE || bus.HREADY) w_dstate_nx = w_addr_done ? D_ACT : D_IDLE;
    end

    always_ff @(posedge HCLK or posedge HRESET)
        if (HRESET) r_dstate <= D_IDLE;
        else r_dstate <= w_dstate_nx;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_up        <= 1'b0;
            r_htrans    <= HTRANS_IDLE;
            r_haddr     <= '0;
            r_hwrite    <= 1'b0;
            r_hsize     <= HSIZE_BYTE;
            r_awdata    <= '0;
            r_hwdata    <= '0;
            r_d_write   <= 1'b0;
            r_d_size    <= HSIZE_BYTE;
            r_d_lo      <= '0;
            r_cancel    <= 1'b0;
            r_cxl_rsp   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_up <= 1'b1;
            if (w_cancel) r_htrans <= HTRANS_IDLE;
            else if (w_accept) begin
                r_htrans <= HTRANS_NONSEQ;
                r_haddr  <= bus.cmd_addr;
                r_hwrite <= bus.cmd_write;
                r_hsize  <= to_hsize(bus.cmd_size);
                r_awdata <= lane_replicate(bus.cmd_wdata, to_hsize(bus.cmd_size));
            end else if (w_addr_done) r_htrans <= HTRANS_IDLE;
            if (w_addr_done) begin
                r_hwdata  <= r_awdata;
                r_d_write <= r_hwrite;
                r_d_size  <= r_hsize;
                r_d_lo    <= r_haddr[1:0];
            end
            r_cancel    <= w_cancel || (r_cancel && !w_err_end);
            r_cxl_rsp   <= r_cancel && w_err_end;
            r_rsp_valid <= w_data_done || r_cxl_rsp;
            r_rsp_error <= w_data_done ? w_rsp_err : r_cxl_rsp;
            r_rsp_rdata <= (w_data_done && !w_rsp_err && !r_d_write) ? lane_extract(bus.HRDATA, r_d_lo, r_d_size) : '0;
        end
    end

    assign bus.cmd_ready = w_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_error = r_rsp_error;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.HTRANS    = r_htrans;
    assign bus.HADDR     = r_haddr;
    assign bus.HWRITE    = r_hwrite;
    assign bus.HSIZE     = r_hsize;
    assign bus.HWDATA    = r_hwdata;
    assign bus.HBURST    = HBURST_SINGLE;
    assign bus.HPROT     = HPROT_DATA_PRIV;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed cycle-by-cycle stimulus with a response scoreboard
module tb_ahb_lite_master;
    typedef struct packed {logic err; logic [31:0] rdata;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    exp_t q[$];
    exp_t m_e;

    ahb_lite_master_if bus();
    ahb_lite_master dut (.HCLK(clk), .HRESET(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, want);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = s;
        bus.cmd_wdata = d;
    endtask

    task automatic push_exp(input logic e, input logic [31:0] d);
        q.push_back({e, d});
    endtask

    always @(negedge clk)
        if (bus.rsp_valid === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
            end else begin
                m_e = q.pop_front();
                chk("rsp_error", 32'(bus.rsp_error), 32'(m_e.err));
                chk("rsp_rdata", bus.rsp_rdata, m_e.rdata);
            end
        end

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_size = '0; bus.cmd_wdata = '0;
        bus.HRDATA = '0; bus.HREADY = 1'b1; bus.HRESP = 2'b00;
        step(); step(); #1;
        chk("rst_htrans", 32'(bus.HTRANS), 0);
        chk("rst_haddr", bus.HADDR, 0);
        chk("rst_hwrite", 32'(bus.HWRITE), 0);
        chk("rst_hsize", 32'(bus.HSIZE), 0);
        chk("rst_hwdata", bus.HWDATA, 0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("rst_hburst", 32'(bus.HBURST), 0);
        chk("rst_hprot", 32'(bus.HPROT), 3);
        step(); rst = 1'b0; #1;
        chk("ready_before_edge", 32'(bus.cmd_ready), 0);
        step(); #1;
        chk("ready_after_rst", 32'(bus.cmd_ready), 1);

        // word write, zero waits
        step(); issue(1'b1, 32'h1000, 2'd2, 32'hDEADBEEF); push_exp(1'b0, 0); #1;
        chk("t1_ready", 32'(bus.cmd_ready), 1);
        step(); bus.cmd_valid = 1'b0; #1;
        chk("t1_htrans", 32'(bus.HTRANS), 2);
        chk("t1_haddr", bus.HADDR, 32'h1000);
        chk("t1_hwrite", 32'(bus.HWRITE), 1);
        chk("t1_hsize", 32'(bus.HSIZE), 2);
        step(); #1;
        chk("t1_idle", 32'(bus.HTRANS), 0);
        chk("t1_hwdata", bus.HWDATA, 32'hDEADBEEF);
        step(); #1;
        chk("t1_rsp", 32'(bus.rsp_valid), 1);
        step(); #1;
        chk("t1_rsp_pulse", 32'(bus.rsp_valid), 0);

        // byte read at offset 3 with two wait states
        step(); issue(1'b0, 32'h1003, 2'd0, 0); push_exp(1'b0, 32'hAB); #1;
        step(); bus.cmd_valid = 1'b0; #1;
        chk("t2_htrans", 32'(bus.HTRANS), 2);
        chk("t2_haddr", bus.HADDR, 32'h1003);
        chk("t2_hsize", 32'(bus.HSIZE), 0);
        chk("t2_hwrite", 32'(bus.HWRITE), 0);
        step(); bus.HREADY = 1'b0; #1;
        chk("t2_wait_idle", 32'(bus.HTRANS), 0);
        step(); #1;
        chk("t2_hold_addr", bus.HADDR, 32'h1003);
        chk("t2_no_rsp", 32'(bus.rsp_valid), 0);
        step(); bus.HREADY = 1'b1; bus.HRDATA = 32'hAB000000;
        step(); bus.HRDATA = 0; #1;
        chk("t2_rsp", 32'(bus.rsp_valid), 1);

        // back-to-back write/read
        step(); issue(1'b1, 32'h0, 2'd2, 32'h11223344); push_exp(1'b0, 0); #1;
        step(); issue(1'b0, 32'h4, 2'd2, 0); push_exp(1'b0, 32'h55667788); #1;
        chk("t3_htrans_w", 32'(bus.HTRANS), 2);
        chk("t3_haddr_w", bus.HADDR, 0);
        chk("t3_ready_pipe", 32'(bus.cmd_ready), 1);
        step(); bus.cmd_valid = 1'b0; #1;
        chk("t3_htrans_r", 32'(bus.HTRANS), 2);
        chk("t3_haddr_r", bus.HADDR, 4);
        chk("t3_hwrite_r", 32'(bus.HWRITE), 0);
        chk("t3_hwdata", bus.HWDATA, 32'h11223344);
        step(); bus.HRDATA = 32'h55667788; #1;
        chk("t3_rsp_w", 32'(bus.rsp_valid), 1);
        chk("t3_idle", 32'(bus.HTRANS), 0);
        step(); bus.HRDATA = 0; #1;
        chk("t3_rsp_r", 32'(bus.rsp_valid), 1);

        // byte lane replication, halfword extraction, size 3 promoted to word
        step(); issue(1'b1, 32'h7, 2'd0, 32'h000000A5); push_exp(1'b0, 0);
        step(); issue(1'b0, 32'h2, 2'd1, 0); push_exp(1'b0, 32'hCAFE);
        step(); issue(1'b1, 32'h8, 2'd3, 32'h01020304); push_exp(1'b0, 0); #1;
        chk("t4_hwdata_byte", bus.HWDATA, 32'hA5A5A5A5);
        chk("t4_hsize_half", 32'(bus.HSIZE), 1);
        step(); bus.cmd_valid = 1'b0; bus.HRDATA = 32'hCAFE1234; #1;
        chk("t4_hsize_3", 32'(bus.HSIZE), 2);
        step(); bus.HRDATA = 0; #1;
        chk("t4_hwdata_word", bus.HWDATA, 32'h01020304);
        step(); step();

        // two-cycle ERROR on a write with a read queued behind it
        step(); issue(1'b1, 32'hF0000000, 2'd2, 32'h12345678); push_exp(1'b1, 0);
        step(); issue(1'b0, 32'h8, 2'd2, 0); push_exp(1'b1, 0); #1;
        chk("t5_htrans", 32'(bus.HTRANS), 2);
        step(); bus.cmd_valid = 1'b0; bus.HREADY = 1'b0; bus.HRESP = 2'b01; #1;
        chk("t5_ready_err", 32'(bus.cmd_ready), 0);
        chk("t5_haddr_r", bus.HADDR, 8);
        step(); bus.HREADY = 1'b1; #1;
        chk("t5_cancel_idle", 32'(bus.HTRANS), 0);
        chk("t5_ready_cancel", 32'(bus.cmd_ready), 0);
        step(); bus.HRESP = 2'b00; #1;
        chk("t5_rsp1", 32'(bus.rsp_valid), 1);
        step(); #1;
        chk("t5_rsp2", 32'(bus.rsp_valid), 1);
        step(); #1;
        chk("t5_rsp_end", 32'(bus.rsp_valid), 0);

        // ERROR with HREADY high and no wait cycle
        step(); issue(1'b0, 32'h10, 2'd2, 0); push_exp(1'b1, 0);
        step(); bus.cmd_valid = 1'b0;
        step(); bus.HRESP = 2'b01; bus.HRDATA = 32'hFFFFFFFF;
        step(); bus.HRESP = 2'b00; bus.HRDATA = 0; #1;
        chk("t6_rsp", 32'(bus.rsp_valid), 1);

        // reset in the middle of a data phase
        step(); issue(1'b0, 32'h20, 2'd2, 0);
        step(); bus.cmd_valid = 1'b0;
        step(); bus.HREADY = 1'b0;
        step(); rst = 1'b1; #1;
        chk("t7_htrans", 32'(bus.HTRANS), 0);
        chk("t7_haddr", bus.HADDR, 0);
        chk("t7_ready", 32'(bus.cmd_ready), 0);
        chk("t7_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t7_hprot", 32'(bus.HPROT), 3);
        step(); rst = 1'b0; bus.HREADY = 1'b1; #1;
        chk("t7_ready_low", 32'(bus.cmd_ready), 0);
        step(); issue(1'b1, 32'h30, 2'd2, 32'hA5A5A5A5); push_exp(1'b0, 0); #1;
        chk("t7_ready_high", 32'(bus.cmd_ready), 1);
        step(); bus.cmd_valid = 1'b0; #1;
        chk("t7_htrans_new", 32'(bus.HTRANS), 2);
        chk("t7_haddr_new", bus.HADDR, 32'h30);
        step(); #1;
        chk("t7_hwdata_new", bus.HWDATA, 32'hA5A5A5A5);
        step(); #1;
        chk("t7_rsp", 32'(bus.rsp_valid), 1);
        repeat (3) step();
        #1;
        chk("queue_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
